// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned DEFAULT_BAUD     = 115200;
    localparam int unsigned DEFAULT_CLK_FREQ = 81_000_000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO: push/full on the write side, valid/ready on the read side.
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             pop, push_ok;

    assign full_o       = (count_q == FULL_CNT);
    assign dout_valid_o = (count_q != '0);
    assign dout_o       = mem_q[rd_ptr_q];
    assign pop          = dout_valid_o && dout_ready_i;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign push_ok      = push_i && (!full_o || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a 4-entry output FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxp,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LOAD   = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shreg_q;
    logic          push_q, fe_q, overrun_q;
    logic          fifo_full;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[0], uart_rxp};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            fe_q   <= 1'b0;
            unique case (state_q)
                IDLE: if (!rx_s) begin
                    cnt_q   <= HALF_LOAD;
                    state_q <= START;
                end
                // A start bit that is gone by mid-bit is treated as a glitch.
                START: if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_q   <= BIT_LOAD;
                        idx_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                DATA: if (cnt_q == '0) begin
                    shreg_q[idx_q] <= rx_s;
                    cnt_q          <= BIT_LOAD;
                    if (idx_q == 3'd7) state_q <= STOP;
                    else               idx_q   <= idx_q + 3'd1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                STOP: if (cnt_q == '0) begin
                    if (rx_s) begin
                        push_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        fe_q    <= 1'b1;
                        state_q <= WAIT_IDLE;
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                WAIT_IDLE: if (rx_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= push_q && fifo_full && !(dout_valid && dout_ready);
    end

    rx_fifo #(
        .WIDTH(8),
        .DEPTH(4)
    ) u_fifo (
        .clk          (clk),
        .rst_i        (reset),
        .push_i       (push_q),
        .din_i        (shreg_q),
        .full_o       (fifo_full),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready)
    );

    assign busy          = (state_q != IDLE);
    assign framing_error = fe_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 81_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate.
REQ-003 SHALL have ports: clk  in  1  single clock for all logic; reset is asynchronous and active-high.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high; clears all state.
REQ-005 SHALL have port uart_rxp  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
REQ-006 SHALL have port dout  out  8  received byte at FIFO head.
REQ-007 SHALL have port dout_valid  out  1  FIFO non-empty.
REQ-008 SHALL have port dout_ready  in  1  consumer accepts dout when dout_valid is high.
REQ-009 SHALL have port busy  out  1  high while a frame is being received (state != IDLE).
REQ-010 SHALL have port framing_error  out  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port overrun  out  1  one-cycle pulse, completed byte dropped because FIFO full.

Function
REQ-012 SHALL define CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 703 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (351).
REQ-013 SHALL pass uart_rxp through a 2-flop synchronizer with both flops reset to 1; all decoding uses the synchronized signal rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on rx_s==0, load bit counter with HALF_BIT-1, go to START.
REQ-016 START: when counter reaches 0, if rx_s==0 go to DATA with counter CLKS_PER_BIT-1 and bit index 0; else (glitch) go to IDLE with no output.
REQ-017 DATA: each time counter reaches 0, shift rx_s into bit[index] (LSB first) and reload CLKS_PER_BIT-1; after index 7 go to STOP.
REQ-018 STOP: when counter reaches 0, if rx_s==1 push byte and go to IDLE; else pulse framing_error, drop byte, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rx_s==1, then go to IDLE.
REQ-020 The pushed byte SHALL appear on dout/dout_valid the cycle after the stop-bit sample if FIFO was empty.
REQ-021 FIFO SHALL be 4 entries deep, first-in first-out. A pop occurs on a cycle where dout_valid && dout_ready.
REQ-022 A push SHALL be accepted when FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise the byte is dropped and overrun pulses; FIFO contents are unchanged.
REQ-023 Simultaneous push and pop on an empty FIFO is impossible, since dout_valid is 0. On a non-empty FIFO, count is unchanged and order is preserved.
REQ-024 dout SHALL hold its value while dout_valid && !dout_ready.
REQ-025 framing_error and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 On reset, state SHALL be IDLE and the FIFO empty. Outputs: dout=0x00, dout_valid=0, busy=0, framing_error=0, overrun=0. Synchronizer flops SHALL be 1.
REQ-027 Reset mid-frame SHALL discard the partial byte. After release, reception resumes only on the next falling edge seen in IDLE.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding, DEFAULT_BAUD=115200, and the CLKS_PER_BIT/HALF_BIT derivation. The existing transmitter SHALL reuse the same constants.
REQ-029 The FIFO SHALL be a sub-module rx_fifo (parameterized width 8, depth 4, valid/ready on the read side, push/full on the write side).
REQ-030 Bit counter SHALL be sized to $clog2(CLKS_PER_BIT).

Verification
REQ-031 Frame 0x55 at defaults, dout_ready=1 -> dout=0x55 and dout_valid=1 exactly HALF_BIT+9*CLKS_PER_BIT+3 cycles after the falling edge on uart_rxp (±1); no error pulses.
REQ-032 uart_rxp low for 100 cycles, then high -> no dout_valid, no error pulse; busy high for at most HALF_BIT+3 cycles.
REQ-033 Frame 0xA3 with stop bit low, line held low 2 bit times, then high -> framing_error one pulse, no byte. Next frame 0x3C is received correctly.
REQ-034 Bytes 0x01..0x05 back-to-back with dout_ready=0 -> overrun one pulse on the 5th byte. Raising dout_ready then yields 0x01,0x02,0x03,0x04 in order, and dout_valid falls.
REQ-035 Reset asserted during bit 4 of a frame -> all outputs at reset values within 1 cycle. Frame 0xFF sent after release is received as 0xFF.
REQ-036 CLK_FREQ=27_000_000, BAUD=115200: 16 consecutive random bytes with zero idle gap -> all 16 received in order, no error pulses.
